pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 64: width of the valC, valA and valB fields.
REQ-002 SHALL provide parameter REG_W, default 4: width of the dstE, dstM, srcA and srcB fields.
REQ-003 SHALL provide parameter CNT_W, default 16: width of the stall and bubble event counters.
REQ-004 SHALL provide parameters INOP=4'h1, FNONE=4'h0, RNONE={REG_W{1'b1}} and STAT_BUB=3'd0: the bubble encodings.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port stall, input, 1 bit: hold all payload fields.
REQ-008 SHALL have port bubble, input, 1 bit: inject a NOP bubble.
REQ-009 SHALL have ports d_stat / q_stat, input / output, 3 bits: stage status.
REQ-010 SHALL have ports d_icode / q_icode, input / output, 4 bits: instruction code.
REQ-011 SHALL have ports d_ifun / q_ifun, input / output, 4 bits: function code.
REQ-012 SHALL have ports d_valC, d_valA, d_valB / q_valC, q_valA, q_valB, input / output, DATA_W bits each: data operands.
REQ-013 SHALL have ports d_dstE, d_dstM / q_dstE, q_dstM, input / output, REG_W bits each: destination register IDs.
REQ-014 SHALL have ports d_srcA, d_srcB / q_srcA, q_srcB, input / output, REG_W bits each: source register IDs.
REQ-015 SHALL have port q_valid, output, 1 bit: the register holds a real instruction, not a bubble.
REQ-016 SHALL have port stall_cnt, output, CNT_W bits: count of stall cycles, saturating.
REQ-017 SHALL have port bubble_cnt, output, CNT_W bits: count of bubble cycles, saturating.
REQ-018 SHALL have port conflict, output, 1 bit: sticky flag, set when stall and bubble are asserted in the same cycle.

Function
REQ-019 SHALL have 1-cycle latency: a d_* value sampled at rising edge N SHALL appear on q_* after edge N, with no combinational path from d_* to q_*.
REQ-020 SHALL apply update priority per edge in this order: reset, then stall, then bubble, then normal load.
REQ-021 SHALL, on normal load (stall=0, bubble=0), register every d_* field into its q_* field and set q_valid=1.
REQ-022 SHALL, on stall=1, hold every q_* field and q_valid unchanged; stall_cnt SHALL increment by 1.
REQ-023 SHALL, on bubble=1 with stall=0, load q_icode=INOP, q_ifun=FNONE, q_stat=STAT_BUB, q_dstE/q_dstM/q_srcA/q_srcB=RNONE and q_valC/q_valA/q_valB=0, clear q_valid, and increment bubble_cnt by 1.
REQ-024 SHALL ensure every bubble leaves no stale destination IDs, so that forwarding logic never matches a squashed instruction.
REQ-025 SHALL, on stall=1 with bubble=1, let stall win (hold), increment stall_cnt only, and set conflict=1.
REQ-026 SHALL keep conflict set until reset once it has been set.
REQ-027 SHALL saturate both counters at all-ones: a further event SHALL leave the counter at all-ones and SHALL not wrap to 0.
REQ-028 SHALL change each counter by at most 1 per cycle and SHALL count no event during a reset cycle.
REQ-029 SHALL keep all behaviour correct for any DATA_W >= 1 and any REG_W >= 1; the bubble values SHALL scale with the parameters.

Reset
REQ-030 SHALL, at a rising edge with rst_n=0 and regardless of stall or bubble, load the bubble values of REQ-023 into all payload fields, clear q_valid, clear stall_cnt and bubble_cnt to 0, and clear conflict to 0.
REQ-031 SHALL let a reset asserted mid-stall or mid-bubble take effect at that same edge, and SHALL load d_* normally on the first edge after rst_n returns to 1.

Verification
REQ-032 SHALL cover reset: rst_n=0 for 2 cycles with stall=1 and bubble=1 -> q_icode=1, q_dstE=4'hF, q_valA=0, q_valid=0, both counters 0, conflict=0.
REQ-033 SHALL cover normal load then stall: load d_icode=6, d_valA=64'h1234, d_dstE=3, then stall=1 for 3 cycles with new d_* values -> q_* stay icode 6 / valA 0x1234 / dstE 3, and stall_cnt=3.
REQ-034 SHALL cover bubble: bubble=1 for 1 cycle after a valid load -> q_icode=1, q_ifun=0, q_stat=0, q_dstM=4'hF, q_valid=0, bubble_cnt=1; the next normal cycle reloads d_*.
REQ-035 SHALL cover the conflict case: stall=1 and bubble=1 together -> q_* held, stall_cnt increments, bubble_cnt unchanged, conflict=1 and still 1 ten cycles later.
REQ-036 SHALL cover saturation: with CNT_W=4, 20 consecutive stall cycles -> stall_cnt=4'hF, with no wrap.
REQ-037 SHALL cover a parameter sweep: with DATA_W=32 and REG_W=5, a bubble -> q_dstE=5'h1F and q_valC=32'h0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline register stage with stall/bubble control and event counters
module pipe_stage_reg #(
  parameter int                DATA_W   = 64,
  parameter int                REG_W    = 4,
  parameter int                CNT_W    = 16,
  parameter logic [3:0]        INOP     = 4'h1,
  parameter logic [3:0]        FNONE    = 4'h0,
  parameter logic [REG_W-1:0]  RNONE    = {REG_W{1'b1}},
  parameter logic [2:0]        STAT_BUB = 3'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              bubble,
  input  logic [2:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [DATA_W-1:0] d_valA,
  input  logic [DATA_W-1:0] d_valB,
  input  logic [REG_W-1:0]  d_dstE,
  input  logic [REG_W-1:0]  d_dstM,
  input  logic [REG_W-1:0]  d_srcA,
  input  logic [REG_W-1:0]  d_srcB,
  output logic [2:0]        q_stat,
  output logic [3:0]        q_icode,
  output logic [3:0]        q_ifun,
  output logic [DATA_W-1:0] q_valC,
  output logic [DATA_W-1:0] q_valA,
  output logic [DATA_W-1:0] q_valB,
  output logic [REG_W-1:0]  q_dstE,
  output logic [REG_W-1:0]  q_dstM,
  output logic [REG_W-1:0]  q_srcA,
  output logic [REG_W-1:0]  q_srcB,
  output logic              q_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              conflict
);

  logic [2:0]        r_stat;
  logic [3:0]        r_icode, r_ifun;
  logic [DATA_W-1:0] r_valC, r_valA, r_valB;
  logic [REG_W-1:0]  r_dstE, r_dstM, r_srcA, r_srcB;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall_cnt, r_bubble_cnt;
  logic              r_conflict;

  logic w_squash, w_load, w_stall_sat, w_bubble_sat;

  // Reset and an unstalled bubble both leave the stage holding a clean NOP.
  assign w_squash     = !rst_n || (!stall && bubble);
  assign w_load       = rst_n && !stall && !bubble;
  assign w_stall_sat  = &r_stall_cnt;
  assign w_bubble_sat = &r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (w_squash) begin
      r_stat  <= STAT_BUB;
      r_icode <= INOP;
      r_ifun  <= FNONE;
      r_valC  <= '0;
      r_valA  <= '0;
      r_valB  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_srcA  <= RNONE;
      r_srcB  <= RNONE;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_stat  <= d_stat;
      r_icode <= d_icode;
      r_ifun  <= d_ifun;
      r_valC  <= d_valC;
      r_valA  <= d_valA;
      r_valB  <= d_valB;
      r_dstE  <= d_dstE;
      r_dstM  <= d_dstM;
      r_srcA  <= d_srcA;
      r_srcB  <= d_srcB;
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_conflict   <= 1'b0;
    end else if (stall) begin
      if (!w_stall_sat) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bubble)       r_conflict  <= 1'b1;
    end else if (bubble) begin
      if (!w_bubble_sat) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign q_stat     = r_stat;
  assign q_icode    = r_icode;
  assign q_ifun     = r_ifun;
  assign q_valC     = r_valC;
  assign q_valA     = r_valA;
  assign q_valB     = r_valB;
  assign q_dstE     = r_dstE;
  assign q_dstM     = r_dstM;
  assign q_srcA     = r_srcA;
  assign q_srcB     = r_srcB;
  assign q_valid    = r_valid;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign conflict   = r_conflict;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized bench for pipe_stage_reg against a cycle model
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, bubble;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [4:0]  d_dstE, d_dstM, d_srcA, d_srcB;

  logic [2:0]  q_stat;
  logic [3:0]  q_icode, q_ifun;
  logic [63:0] q_valC, q_valA, q_valB;
  logic [3:0]  q_dstE, q_dstM, q_srcA, q_srcB;
  logic        q_valid, q_conflict;
  logic [15:0] q_stall_cnt, q_bubble_cnt;

  logic [2:0]  s_stat;
  logic [3:0]  s_icode, s_ifun;
  logic [31:0] s_valC, s_valA, s_valB;
  logic [4:0]  s_dstE, s_dstM, s_srcA, s_srcB;
  logic        s_valid, s_conflict;
  logic [3:0]  s_stall_cnt, s_bubble_cnt;

  pipe_stage_reg u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE[3:0]), .d_dstM(d_dstM[3:0]), .d_srcA(d_srcA[3:0]), .d_srcB(d_srcB[3:0]),
    .q_stat(q_stat), .q_icode(q_icode), .q_ifun(q_ifun),
    .q_valC(q_valC), .q_valA(q_valA), .q_valB(q_valB),
    .q_dstE(q_dstE), .q_dstM(q_dstM), .q_srcA(q_srcA), .q_srcB(q_srcB),
    .q_valid(q_valid), .stall_cnt(q_stall_cnt), .bubble_cnt(q_bubble_cnt), .conflict(q_conflict)
  );

  // Narrow variant: small counters for saturation, odd widths for scaling.
  pipe_stage_reg #(.DATA_W(32), .REG_W(5), .CNT_W(4)) u_sw (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC[31:0]), .d_valA(d_valA[31:0]), .d_valB(d_valB[31:0]),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .q_stat(s_stat), .q_icode(s_icode), .q_ifun(s_ifun),
    .q_valC(s_valC), .q_valA(s_valA), .q_valB(s_valB),
    .q_dstE(s_dstE), .q_dstM(s_dstM), .q_srcA(s_srcA), .q_srcB(s_srcB),
    .q_valid(s_valid), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt), .conflict(s_conflict)
  );

  logic [2:0]  m_stat;
  logic [3:0]  m_icode, m_ifun;
  logic [63:0] m_valC, m_valA, m_valB;
  logic [4:0]  m_dstE, m_dstM, m_srcA, m_srcB;
  logic        m_valid, m_conf;
  int          m_scnt, m_bcnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int top);
    return (v > top) ? top : v;
  endfunction

  task automatic model_squash();
    m_stat = 3'd0; m_icode = 4'h1; m_ifun = 4'h0;
    m_valC = '0; m_valA = '0; m_valB = '0;
    m_dstE = '1; m_dstM = '1; m_srcA = '1; m_srcB = '1;
    m_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_squash();
      m_scnt = 0; m_bcnt = 0; m_conf = 1'b0;
    end else if (stall) begin
      m_scnt++;
      if (bubble) m_conf = 1'b1;
    end else if (bubble) begin
      model_squash();
      m_bcnt++;
    end else begin
      m_stat = d_stat; m_icode = d_icode; m_ifun = d_ifun;
      m_valC = d_valC; m_valA = d_valA; m_valB = d_valB;
      m_dstE = d_dstE; m_dstM = d_dstM; m_srcA = d_srcA; m_srcB = d_srcB;
      m_valid = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("stat", q_stat, m_stat);
    chk("icode", q_icode, m_icode);
    chk("ifun", q_ifun, m_ifun);
    chk("valC", q_valC, m_valC);
    chk("valA", q_valA, m_valA);
    chk("valB", q_valB, m_valB);
    chk("dstE", q_dstE, m_dstE[3:0]);
    chk("dstM", q_dstM, m_dstM[3:0]);
    chk("srcA", q_srcA, m_srcA[3:0]);
    chk("srcB", q_srcB, m_srcB[3:0]);
    chk("valid", q_valid, m_valid);
    chk("stall_cnt", q_stall_cnt, sat(m_scnt, 65535));
    chk("bubble_cnt", q_bubble_cnt, sat(m_bcnt, 65535));
    chk("conflict", q_conflict, m_conf);
    chk("sw_icode", s_icode, m_icode);
    chk("sw_valC", s_valC, m_valC[31:0]);
    chk("sw_valA", s_valA, m_valA[31:0]);
    chk("sw_dstE", s_dstE, m_dstE);
    chk("sw_srcB", s_srcB, m_srcB);
    chk("sw_valid", s_valid, m_valid);
    chk("sw_stall_cnt", s_stall_cnt, sat(m_scnt, 15));
    chk("sw_bubble_cnt", s_bubble_cnt, sat(m_bcnt, 15));
    chk("sw_conflict", s_conflict, m_conf);
  endtask

  task automatic rand_d();
    d_stat = 3'($urandom); d_icode = 4'($urandom); d_ifun = 4'($urandom);
    d_valC = {$urandom, $urandom}; d_valA = {$urandom, $urandom}; d_valB = {$urandom, $urandom};
    d_dstE = 5'($urandom); d_dstM = 5'($urandom); d_srcA = 5'($urandom); d_srcB = 5'($urandom);
  endtask

  task automatic step(input logic r, input logic s, input logic b);
    rst_n = r; stall = s; bubble = b;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    rand_d();
  endtask

  initial begin
    rand_d();
    m_scnt = 0; m_bcnt = 0; m_conf = 1'b0;
    model_squash();
    @(negedge clk);

    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("rst_icode", q_icode, 4'h1);
    chk("rst_dstE", q_dstE, 4'hF);
    chk("rst_valA", q_valA, 64'h0);
    chk("rst_stall_cnt", q_stall_cnt, 16'h0);

    d_icode = 4'h6; d_valA = 64'h1234; d_dstE = 5'h3;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("hold_icode", q_icode, 4'h6);
    chk("hold_valA", q_valA, 64'h1234);
    chk("hold_dstE", q_dstE, 4'h3);
    chk("stall_cnt3", q_stall_cnt, 16'd3);

    step(1'b1, 1'b0, 1'b1);
    chk("bub_icode", q_icode, 4'h1);
    chk("bub_dstM", q_dstM, 4'hF);
    chk("bub_valid", q_valid, 1'b0);
    chk("bub_cnt1", q_bubble_cnt, 16'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("reload_valid", q_valid, 1'b1);

    step(1'b1, 1'b1, 1'b1);
    chk("conf_set", q_conflict, 1'b1);
    chk("conf_bub_cnt", q_bubble_cnt, 16'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    chk("conf_sticky", q_conflict, 1'b1);

    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    chk("sat_stall", s_stall_cnt, 4'hF);

    step(1'b1, 1'b0, 1'b1);
    chk("sw_bub_dstE", s_dstE, 5'h1F);
    chk("sw_bub_valC", s_valC, 32'h0);

    // Reset landing in the middle of a stall run must still win at that edge.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("midstall_rst_cnt", q_stall_cnt, 16'd0);

    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));

    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1);
    chk("sat_bubble", s_bubble_cnt, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
